sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search_pkg.sv | 12 +
 rtl/sar_search.sv | 126 ++++++++++++
 tb/tb_sar_search.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and defaults for the successive-approximation search block.
package sar_search_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_t;

endpackage

// File: rtl/sar_search.sv
// Binary search of an unknown target using an external magnitude comparator,
// one compare per cycle, narrowing [lo, hi] until equal, exhausted or flags invalid.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic [WIDTH-1:0]               guess,
  input  logic                           cmp_greater,
  input  logic                           cmp_equal,
  input  logic                           cmp_less,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic                           error,
  output logic [WIDTH-1:0]               result,
  output logic [$clog2(WIDTH+2)-1:0]     probes
);

  localparam int unsigned PW = $clog2(WIDTH + 2);

  state_t           state, state_nx;
  logic [WIDTH-1:0] lo, hi, lo_nx, hi_nx;
  logic [WIDTH-1:0] result_nx;
  logic             found_nx, error_nx;
  logic [PW-1:0]    probes_nx;
  logic [WIDTH:0]   mid_sum;
  logic [WIDTH-1:0] mid;
  logic [2:0]       flags;

  // Extra carry bit keeps lo+hi exact before halving.
  assign mid_sum = {1'b0, lo} + {1'b0, hi};
  assign mid     = WIDTH'(mid_sum >> 1);
  assign flags   = {cmp_greater, cmp_equal, cmp_less};

  assign guess = (state == PROBE) ? mid : '0;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      result <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
      probes <= '0;
    end else begin
      state  <= state_nx;
      lo     <= lo_nx;
      hi     <= hi_nx;
      result <= result_nx;
      found  <= found_nx;
      error  <= error_nx;
      probes <= probes_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    lo_nx     = lo;
    hi_nx     = hi;
    result_nx = result;
    found_nx  = found;
    error_nx  = error;
    probes_nx = probes;
    case (state)
      IDLE: begin
        if (start) begin
          lo_nx     = '0;
          hi_nx     = '1;
          probes_nx = '0;
          found_nx  = 1'b0;
          error_nx  = 1'b0;
          state_nx  = PROBE;
        end
      end
      PROBE: begin
        probes_nx = probes + PW'(1);
        if (!$onehot(flags)) begin
          error_nx  = 1'b1;
          found_nx  = 1'b0;
          result_nx = mid;
          state_nx  = DONE;
        end else if (cmp_equal) begin
          found_nx  = 1'b1;
          result_nx = mid;
          state_nx  = DONE;
        end else if (cmp_greater) begin
          if (mid == '1) begin
            found_nx  = 1'b0;
            result_nx = mid;
            state_nx  = DONE;
          end else begin
            lo_nx = mid + WIDTH'(1);
            if (lo_nx > hi) begin
              found_nx  = 1'b0;
              result_nx = mid;
              state_nx  = DONE;
            end
          end
        end else begin
          if (mid == '0) begin
            found_nx  = 1'b0;
            result_nx = mid;
            state_nx  = DONE;
          end else begin
            hi_nx = mid - WIDTH'(1);
            if (lo > hi_nx) begin
              found_nx  = 1'b0;
              result_nx = mid;
              state_nx  = DONE;
            end
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Randomized bench for sar_search: comparator stub driven from a target,
// per-search behavioural model of the guess sequence and final status.
module tb_sar_search;
  import sar_search_pkg::*;

  localparam int unsigned W    = DEFAULT_WIDTH;
  localparam int          MAXV = (1 << W) - 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       start = 1'b0;
  logic [W-1:0]               guess, result;
  logic                       cmp_greater, cmp_equal, cmp_less;
  logic                       busy, done, found, error;
  logic [$clog2(W+2)-1:0]     probes;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
    .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
    .busy(busy), .done(done), .found(found), .error(error),
    .result(result), .probes(probes)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // comparator stub: 0 = honest target, 1 = always less, 2 = bad flags at probe bad_idx
  int         mode = 0, target = 0, bad_idx = 0, k = 0;
  logic [2:0] bad_pat = 3'b000;
  logic [2:0] fl;

  always_comb begin
    fl = {target > int'(guess), target == int'(guess), target < int'(guess)};
    if (mode == 1) fl = 3'b001;
    if (mode == 2 && k == bad_idx) fl = bad_pat;
    {cmp_greater, cmp_equal, cmp_less} = fl;
  end

  int m_g[8];
  int m_n, m_res;
  bit m_found, m_err;

  logic e_busy = 0, e_done = 0, e_found = 0, e_err = 0;
  int   e_guess = 0, e_res = 0, e_probes = 0;
  bit   chk_en = 0;

  function automatic logic [2:0] flags_for(input int g, input int p);
    logic [2:0] f;
    f = {target > g, target == g, target < g};
    if (mode == 1) f = 3'b001;
    if (mode == 2 && p == bad_idx) f = bad_pat;
    return f;
  endfunction

  // Plain-integer binary search following the termination rules.
  task automatic run_model();
    int lo, hi, g;
    logic [2:0] f;
    lo = 0; hi = MAXV; m_n = 0; m_found = 0; m_err = 0; m_res = 0;
    for (int p = 0; p < 8; p++) begin
      g = (lo + hi) / 2;
      m_g[p] = g; m_n = p + 1; m_res = g;
      f = flags_for(g, p);
      if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin m_err = 1; break; end
      if (f == 3'b010) begin m_found = 1; break; end
      if (f == 3'b100) begin
        if (g == MAXV) break;
        lo = g + 1;
      end else begin
        if (g == 0) break;
        hi = g - 1;
      end
      if (lo > hi) break;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("guess", 32'(guess), e_guess);
      check("found", 32'(found), 32'(e_found));
      check("error", 32'(error), 32'(e_err));
      check("result", 32'(result), e_res);
      check("probes", 32'(probes), e_probes);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 0; e_busy = 0; e_done = 0; e_guess = 0;
    end
  endtask

  // One search: idle cycle with start, probe cycles, done cycle. rst_at >= 0 aborts with reset.
  task automatic do_search(input int md, input int t, input int bi, input logic [2:0] bp,
                           input bit keep, input int rst_at);
    mode = md; target = t; bad_idx = bi; bad_pat = bp;
    run_model();
    @(posedge clk); #1;
    start = 1; e_busy = 0; e_done = 0; e_guess = 0;
    @(posedge clk); #1;
    if (!keep) start = 0;
    e_busy = 1; e_found = 0; e_err = 0;
    for (int j = 0; j < m_n; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      k = j; e_guess = m_g[j]; e_probes = j;
      if (j == rst_at) begin
        rst_n = 0; start = 0;
        e_busy = 0; e_done = 0; e_guess = 0; e_found = 0; e_err = 0; e_res = 0; e_probes = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        return;
      end
    end
    @(posedge clk); #1;
    e_done = 1; e_guess = 0; e_found = m_found; e_err = m_err; e_res = m_res; e_probes = m_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0] bad_tab[5];

  initial begin
    bad_tab[0] = 3'b000; bad_tab[1] = 3'b011; bad_tab[2] = 3'b101;
    bad_tab[3] = 3'b110; bad_tab[4] = 3'b111;

    // model pins, hand-derived
    mode = 0; target = 7; run_model();
    check("pin7_n", m_n, 1); check("pin7_g0", m_g[0], 7); check("pin7_found", 32'(m_found), 1);
    target = 15; run_model();
    check("pin15_n", m_n, 5); check("pin15_g1", m_g[1], 11); check("pin15_g2", m_g[2], 13);
    check("pin15_g3", m_g[3], 14); check("pin15_res", m_res, 15);
    target = 0; run_model();
    check("pin0_n", m_n, 4); check("pin0_g2", m_g[2], 1); check("pin0_found", 32'(m_found), 1);
    mode = 1; run_model();
    check("pinless_n", m_n, 4); check("pinless_found", 32'(m_found), 0);
    check("pinless_res", m_res, 0); check("pinless_err", 32'(m_err), 0);
    mode = 2; target = 2; bad_idx = 1; bad_pat = 3'b110; run_model();
    check("piner_n", m_n, 2); check("piner_res", m_res, 3); check("piner_err", 32'(m_err), 1);
    mode = 0;

    #2 rst_n = 0;
    #1 chk_en = 1;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    idle(2);

    do_search(0, 7, 0, 3'b000, 0, -1);  idle(2);
    do_search(0, 15, 0, 3'b000, 0, -1); idle(1);
    do_search(0, 0, 0, 3'b000, 0, -1);  idle(1);
    do_search(1, 0, 0, 3'b000, 0, -1);  idle(1);
    do_search(2, 2, 1, 3'b110, 0, -1);  idle(2);
    do_search(0, 5, 0, 3'b000, 1, -1);
    do_search(0, 12, 0, 3'b000, 0, -1); idle(1);
    do_search(0, 15, 0, 3'b000, 0, 2);  idle(3);
    do_search(0, 9, 0, 3'b000, 0, -1);  idle(2);

    for (int n = 0; n < 300; n++) begin
      int md, rat;
      md  = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
      rat = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_search(md, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 5)),
                bad_tab[$urandom_range(0, 4)], bit'($urandom_range(0, 1)), rat);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
